wta_disparity: RTL and testbench

WTA_DISPARITY -- requirements
Module: wta_disparity

---
 rtl/stereo_pkg.sv | 17 +
 rtl/wta_cmp_cell.sv | 50 +++++
 rtl/wta_disparity.sv | 111 +++++++++++
 tb/tb_wta_disparity.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared stereo-pipeline types and helpers: default cost width, disparity index
// width helper, and cost/disparity typedefs used by the WTA stage.
package stereo_pkg;

  localparam int unsigned CW_DEF    = 5;
  localparam int unsigned NDISP_DEF = 64;
  localparam int unsigned DW_MAX    = 8;

  typedef logic [CW_DEF-1:0] cost_t;
  typedef logic [DW_MAX-1:0] disp_t;

  // Disparity index width: clog2(n), never narrower than one bit.
  function automatic int unsigned disp_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wta_cmp_cell.sv
// Compare-select cell: folds one cost into the running minimum (and the
// second-best cost when STEREO_WTA_UNIQUENESS_EN is defined).
module wta_cmp_cell
  import stereo_pkg::*;
#(
  parameter int unsigned CW = CW_DEF,
  parameter int unsigned DW = 6
) (
  input  logic          i_first,
  input  logic [CW-1:0] i_cost,
  input  logic [DW-1:0] i_idx,
  input  logic [CW-1:0] i_min,
  input  logic [DW-1:0] i_min_idx,
`ifdef STEREO_WTA_UNIQUENESS_EN
  input  logic [CW-1:0] i_second,
  output logic [CW-1:0] o_second_c,
`endif
  output logic [CW-1:0] o_min_c,
  output logic [DW-1:0] o_idx_c
);

  logic w_lt;

  assign w_lt = (i_cost < i_min);

  // Strict less-than keeps the lower disparity on ties.
  always_comb begin
    o_min_c = i_min;
    o_idx_c = i_min_idx;
    if (i_first || w_lt) begin
      o_min_c = i_cost;
      o_idx_c = i_idx;
    end
  end

`ifdef STEREO_WTA_UNIQUENESS_EN
  // A displaced minimum becomes second-best; a cost equal to the minimum counts too.
  always_comb begin
    o_second_c = i_second;
    if (i_first) begin
      o_second_c = '1;
    end else if (w_lt) begin
      o_second_c = i_min;
    end else if (i_cost < i_second) begin
      o_second_c = i_cost;
    end
  end
`endif

endmodule

// File: rtl/wta_disparity.sv
// Winner-take-all disparity selection over NDISP streamed costs per pixel.
// Optional second-best uniqueness test enabled by STEREO_WTA_UNIQUENESS_EN.
module wta_disparity
  import stereo_pkg::*;
#(
  parameter  int unsigned NDISP   = NDISP_DEF,
  parameter  int unsigned CW      = CW_DEF,
  parameter  int unsigned UNIQ_TH = 2,
  localparam int unsigned DW      = disp_width(NDISP)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_dval,
  input  logic          i_sop,
  input  logic [CW-1:0] i_cost,
  output logic          o_dval,
  output logic [DW-1:0] o_disp,
  output logic [CW-1:0] o_cost,
  output logic          o_unique
);

  if (NDISP < 2 || NDISP > 256 || UNIQ_TH > (1 << CW)) begin : g_bad_param
    $error("wta_disparity: illegal NDISP/UNIQ_TH");
  end

  logic [DW-1:0] r_cnt;
  logic [CW-1:0] r_min;
  logic [DW-1:0] r_min_idx;

  logic          w_first;
  logic          w_last;
  logic [DW-1:0] w_idx;
  logic [DW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_min;
  logic [DW-1:0] w_min_idx;
  logic          w_unique;

  // i_sop forces disparity 0, which also discards any partial pixel.
  assign w_first   = i_sop || (r_cnt == '0);
  assign w_idx     = i_sop ? '0 : r_cnt;
  assign w_last    = (w_idx == DW'(NDISP - 1));
  assign w_cnt_nxt = w_last ? '0 : w_idx + DW'(1);

`ifdef STEREO_WTA_UNIQUENESS_EN
  logic [CW-1:0] r_second;
  logic [CW-1:0] w_second;
  logic [CW:0]   w_margin;

  assign w_margin = {1'b0, w_second} - {1'b0, w_min};
  assign w_unique = (w_margin >= (CW+1)'(UNIQ_TH));

  wta_cmp_cell #(.CW(CW), .DW(DW)) u_cmp (
    .i_first    (w_first),
    .i_cost     (i_cost),
    .i_idx      (w_idx),
    .i_min      (r_min),
    .i_min_idx  (r_min_idx),
    .i_second   (r_second),
    .o_second_c (w_second),
    .o_min_c    (w_min),
    .o_idx_c    (w_min_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_second <= '1;
    end else if (i_dval) begin
      r_second <= w_second;
    end
  end
`else
  assign w_unique = 1'b1;

  wta_cmp_cell #(.CW(CW), .DW(DW)) u_cmp (
    .i_first    (w_first),
    .i_cost     (i_cost),
    .i_idx      (w_idx),
    .i_min      (r_min),
    .i_min_idx  (r_min_idx),
    .o_min_c    (w_min),
    .o_idx_c    (w_min_idx)
  );
`endif

  // Running state advances only on accepted costs; results pulse for one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_min     <= '0;
      r_min_idx <= '0;
      o_dval    <= 1'b0;
      o_disp    <= '0;
      o_cost    <= '0;
      o_unique  <= 1'b0;
    end else begin
      o_dval <= 1'b0;
      if (i_dval) begin
        r_cnt     <= w_cnt_nxt;
        r_min     <= w_min;
        r_min_idx <= w_min_idx;
        if (w_last) begin
          o_dval   <= 1'b1;
          o_disp   <= w_min_idx;
          o_cost   <= w_min;
          o_unique <= w_unique;
        end
      end
    end
  end

endmodule

// File: tb/tb_wta_disparity.sv
// Directed self-checking bench for wta_disparity with NDISP=4, CW=5, UNIQ_TH=2.
module tb_wta_disparity;

  localparam int unsigned NDISP = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned DW    = 2;
`ifdef STEREO_WTA_UNIQUENESS_EN
  localparam bit UNIQ_EN = 1'b1;
`else
  localparam bit UNIQ_EN = 1'b0;
`endif

  logic          i_clk  = 1'b0;
  logic          i_rst  = 1'b1;
  logic          i_dval = 1'b0;
  logic          i_sop  = 1'b0;
  logic [CW-1:0] i_cost = '0;
  logic          o_dval;
  logic [DW-1:0] o_disp;
  logic [CW-1:0] o_cost;
  logic          o_unique;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q_disp[$];
  logic [CW-1:0] q_cost[$];
  logic          q_uniq[$];

  wta_disparity #(.NDISP(NDISP), .CW(CW), .UNIQ_TH(2)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_dval   (i_dval),
    .i_sop    (i_sop),
    .i_cost   (i_cost),
    .o_dval   (o_dval),
    .o_disp   (o_disp),
    .o_cost   (o_cost),
    .o_unique (o_unique)
  );

  always #5 i_clk = ~i_clk;

  // Record every result pulse, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_dval === 1'b1) begin
      q_disp.push_back(o_disp);
      q_cost.push_back(o_cost);
      q_uniq.push_back(o_unique);
    end
  end

  function automatic int n_pulse();
    return int'(q_disp.size());
  endfunction

  task automatic drive(input logic sop, input logic [CW-1:0] c);
    @(negedge i_clk);
    i_dval = 1'b1;
    i_sop  = sop;
    i_cost = c;
  endtask

  // Gap cycles present cost 0, which would win if wrongly accepted.
  task automatic gap();
    @(negedge i_clk);
    i_dval = 1'b0;
    i_sop  = 1'b0;
    i_cost = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) gap();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    idle(3);
    n_checks++; if (o_dval !== 1'b0) begin n_fail++; $display("FAIL reset_dval: got %b want 0", o_dval); end
    n_checks++; if (o_disp !== 2'd0) begin n_fail++; $display("FAIL reset_disp: got %0d want 0", o_disp); end
    n_checks++; if (o_cost !== 5'd0) begin n_fail++; $display("FAIL reset_cost: got %0d want 0", o_cost); end
    n_checks++; if (o_unique !== 1'b0) begin n_fail++; $display("FAIL reset_unique: got %b want 0", o_unique); end
    i_rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    int base;
    logic exp_u;
    base  = n_pulse();
    exp_u = 1'b1;
    drive(1'b1, 5'd9); drive(1'b0, 5'd3); drive(1'b0, 5'd7); drive(1'b0, 5'd5);
    gap();
    n_checks++; if (o_dval !== 1'b1) begin n_fail++; $display("FAIL basic_latency: o_dval got %b want 1", o_dval); end
    gap();
    n_checks++; if (o_dval !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: o_dval got %b want 0", o_dval); end
    idle(2);
    n_checks++; if (n_pulse() - base !== 1) begin n_fail++; $display("FAIL basic_pulses: got %0d want 1", n_pulse() - base); end
    n_checks++; if (o_disp !== 2'd1) begin n_fail++; $display("FAIL basic_disp: got %0d want 1", o_disp); end
    n_checks++; if (o_cost !== 5'd3) begin n_fail++; $display("FAIL basic_cost: got %0d want 3", o_cost); end
    n_checks++; if (o_unique !== exp_u) begin n_fail++; $display("FAIL basic_unique: got %b want %b", o_unique, exp_u); end
  endtask

  task automatic test_tie();
    int base;
    logic exp_u;
    base  = n_pulse();
    exp_u = UNIQ_EN ? 1'b0 : 1'b1;
    drive(1'b0, 5'd4); drive(1'b0, 5'd2); drive(1'b0, 5'd2); drive(1'b0, 5'd6);
    idle(3);
    n_checks++; if (n_pulse() - base !== 1) begin n_fail++; $display("FAIL tie_pulses: got %0d want 1", n_pulse() - base); end
    n_checks++; if (o_disp !== 2'd1) begin n_fail++; $display("FAIL tie_disp: got %0d want 1", o_disp); end
    n_checks++; if (o_cost !== 5'd2) begin n_fail++; $display("FAIL tie_cost: got %0d want 2", o_cost); end
    n_checks++; if (o_unique !== exp_u) begin n_fail++; $display("FAIL tie_unique: got %b want %b", o_unique, exp_u); end
  endtask

  task automatic test_resync();
    int base;
    base = n_pulse();
    drive(1'b1, 5'd8); drive(1'b0, 5'd1);
    drive(1'b1, 5'd5); drive(1'b0, 5'd5); drive(1'b0, 5'd0); drive(1'b0, 5'd5);
    idle(3);
    n_checks++; if (n_pulse() - base !== 1) begin n_fail++; $display("FAIL resync_pulses: got %0d want 1", n_pulse() - base); end
    n_checks++; if (o_disp !== 2'd2) begin n_fail++; $display("FAIL resync_disp: got %0d want 2", o_disp); end
    n_checks++; if (o_cost !== 5'd0) begin n_fail++; $display("FAIL resync_cost: got %0d want 0", o_cost); end
    n_checks++; if (o_unique !== 1'b1) begin n_fail++; $display("FAIL resync_unique: got %b want 1", o_unique); end
  endtask

  task automatic test_gaps();
    int base;
    logic exp_u;
    base  = n_pulse();
    exp_u = UNIQ_EN ? 1'b0 : 1'b1;
    drive(1'b1, 5'd3); gap(); drive(1'b0, 5'd1); gap(); gap(); drive(1'b0, 5'd2); drive(1'b0, 5'd4);
    idle(3);
    n_checks++; if (n_pulse() - base !== 1) begin n_fail++; $display("FAIL gaps_pulses: got %0d want 1", n_pulse() - base); end
    n_checks++; if (o_disp !== 2'd1) begin n_fail++; $display("FAIL gaps_disp: got %0d want 1", o_disp); end
    n_checks++; if (o_cost !== 5'd1) begin n_fail++; $display("FAIL gaps_cost: got %0d want 1", o_cost); end
    n_checks++; if (o_unique !== exp_u) begin n_fail++; $display("FAIL gaps_unique: got %b want %b", o_unique, exp_u); end
    idle(6);
    n_checks++; if (o_disp !== 2'd1 || o_cost !== 5'd1) begin
      n_fail++; $display("FAIL hold: got disp %0d cost %0d want disp 1 cost 1", o_disp, o_cost);
    end
  endtask

  task automatic test_uniqueness();
    logic exp_u0;
    logic exp_u1;
    exp_u0 = UNIQ_EN ? 1'b0 : 1'b1;
    exp_u1 = 1'b1;
    drive(1'b1, 5'd6); drive(1'b0, 5'd2); drive(1'b0, 5'd3); drive(1'b0, 5'd9);
    idle(2);
    n_checks++; if (o_unique !== exp_u0) begin n_fail++; $display("FAIL uniq_narrow: got %b want %b", o_unique, exp_u0); end
    drive(1'b1, 5'd6); drive(1'b0, 5'd2); drive(1'b0, 5'd5); drive(1'b0, 5'd9);
    idle(2);
    n_checks++; if (o_unique !== exp_u1) begin n_fail++; $display("FAIL uniq_wide: got %b want %b", o_unique, exp_u1); end
    n_checks++; if (o_disp !== 2'd1 || o_cost !== 5'd2) begin
      n_fail++; $display("FAIL uniq_result: got disp %0d cost %0d want disp 1 cost 2", o_disp, o_cost);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = n_pulse();
    drive(1'b1, 5'd5); drive(1'b0, 5'd6);
    @(negedge i_clk);
    i_rst  = 1'b1;
    i_dval = 1'b0;
    i_sop  = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    n_checks++; if (o_cost !== 5'd0 || o_unique !== 1'b0) begin
      n_fail++; $display("FAIL midreset_clear: got cost %0d unique %b want 0 0", o_cost, o_unique);
    end
    drive(1'b0, 5'd7); drive(1'b0, 5'd7); drive(1'b0, 5'd7); drive(1'b0, 5'd1);
    idle(3);
    n_checks++; if (n_pulse() - base !== 1) begin n_fail++; $display("FAIL midreset_pulses: got %0d want 1", n_pulse() - base); end
    n_checks++; if (o_disp !== 2'd3) begin n_fail++; $display("FAIL midreset_disp: got %0d want 3", o_disp); end
    n_checks++; if (o_cost !== 5'd1) begin n_fail++; $display("FAIL midreset_cost: got %0d want 1", o_cost); end
    n_checks++; if (o_unique !== 1'b1) begin n_fail++; $display("FAIL midreset_unique: got %b want 1", o_unique); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic exp_u0;
    base   = n_pulse();
    exp_u0 = UNIQ_EN ? 1'b0 : 1'b1;
    drive(1'b0, 5'd1); drive(1'b0, 5'd2); drive(1'b0, 5'd3); drive(1'b0, 5'd4);
    drive(1'b0, 5'd4); drive(1'b0, 5'd3); drive(1'b0, 5'd2); drive(1'b0, 5'd0);
    idle(3);
    n_checks++; if (n_pulse() - base !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", n_pulse() - base); end
    if (n_pulse() - base >= 1) begin
      n_checks++; if (q_disp[base] !== 2'd0 || q_cost[base] !== 5'd1 || q_uniq[base] !== exp_u0) begin
        n_fail++; $display("FAIL b2b_first: got disp %0d cost %0d unique %b want 0 1 %b", q_disp[base], q_cost[base], q_uniq[base], exp_u0);
      end
    end
    n_checks++; if (o_disp !== 2'd3 || o_cost !== 5'd0 || o_unique !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got disp %0d cost %0d unique %b want 3 0 1", o_disp, o_cost, o_unique);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_resync();
    test_gaps();
    test_uniqueness();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
